// File: rtl/elevator_shaft_if.sv
// Signal bundle between an elevator controller (master) and the shaft model (slave).
interface elevator_shaft_if;
  logic       motor_up;
  logic       motor_down;
  logic       red1;
  logic       red2;
  logic       red3;
  logic [1:0] floor_pos;
  logic       moving;
  logic       fault;

  modport master (
    output motor_up, motor_down,
    input  red1, red2, red3, floor_pos, moving, fault
  );

  modport slave (
    input  motor_up, motor_down,
    output red1, red2, red3, floor_pos, moving, fault
  );
endinterface

// File: rtl/elevator_shaft_model.sv
// Virtual cabin/shaft: motor commands move a tick position, answered with
// active-low floor sensor levels, a floor code and move/fault status.
module elevator_shaft_model #(
  parameter int TICKS_PER_FLOOR = 1000,
  parameter int CLK_DIV         = 50,
  parameter int WIN             = 20,
  parameter int START_FLOOR     = 2
) (
  input  logic       sysclk,
  input  logic       SW0,
  input  logic       motor_up,
  input  logic       motor_down,
  output logic       red1,
  output logic       red2,
  output logic       red3,
  output logic [1:0] floor_pos,
  output logic       moving,
  output logic       fault
);

  localparam int POS_MAX = 2 * TICKS_PER_FLOOR;
  localparam int PW      = $clog2(POS_MAX + 1);
  localparam int CW      = $clog2(CLK_DIV);

  localparam logic [PW-1:0] POS_TOP   = PW'(POS_MAX);
  localparam logic [PW-1:0] POS_RESET = PW'((START_FLOOR - 1) * TICKS_PER_FLOOR);
  localparam logic [PW-1:0] MARK2     = PW'(TICKS_PER_FLOOR);
  localparam logic [CW-1:0] PRESC_TOP = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, FAULT} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] presc_q, presc_d;
  logic [2:0]    red_q;
  logic [1:0]    floor_q;
  logic [2:0]    hit;
  logic          step;

  // Absolute distance taken in whichever order avoids unsigned wrap below zero.
  function automatic logic inWin(input logic [PW-1:0] p, input logic [PW-1:0] mark);
    logic [PW-1:0] diff;
    diff = (p >= mark) ? (p - mark) : (mark - p);
    return diff <= PW'(WIN);
  endfunction

  function automatic logic [1:0] floorCode(input logic [2:0] h);
    if (h[0])      return 2'd1;
    else if (h[1]) return 2'd2;
    else if (h[2]) return 2'd3;
    else           return 2'd0;
  endfunction

  always_ff @(posedge sysclk or negedge SW0) begin
    if (!SW0) begin
      state_q <= IDLE;
      pos_q   <= POS_RESET;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
    end
  end

  assign step = (presc_q == PRESC_TOP);

  // Conflicting commands win over stepping; overtravel freezes pos at the end stop.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = '0;
    unique case (state_q)
      IDLE: begin
        if (motor_up && motor_down) state_d = FAULT;
        else if (motor_up)          state_d = MOVE_UP;
        else if (motor_down)        state_d = MOVE_DOWN;
      end
      MOVE_UP: begin
        if (motor_down)   state_d = FAULT;
        else if (!motor_up) state_d = IDLE;
        else begin
          presc_d = step ? '0 : presc_q + CW'(1);
          if (step) begin
            if (pos_q == POS_TOP) state_d = FAULT;
            else                  pos_d   = pos_q + PW'(1);
          end
        end
      end
      MOVE_DOWN: begin
        if (motor_up)          state_d = FAULT;
        else if (!motor_down)  state_d = IDLE;
        else begin
          presc_d = step ? '0 : presc_q + CW'(1);
          if (step) begin
            if (pos_q == '0) state_d = FAULT;
            else             pos_d   = pos_q - PW'(1);
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  always_comb begin
    moving = 1'b0;
    fault  = 1'b0;
    unique case (state_q)
      MOVE_UP, MOVE_DOWN: moving = 1'b1;
      FAULT:              fault  = 1'b1;
      default:            ;
    endcase
  end

  assign hit = {inWin(pos_q, POS_TOP), inWin(pos_q, MARK2), inWin(pos_q, '0)};

  // Sensors follow pos with one cycle of latency; red lines and floor code share one register stage.
  always_ff @(posedge sysclk or negedge SW0) begin
    if (!SW0) begin
      red_q   <= ~{inWin(POS_RESET, POS_TOP), inWin(POS_RESET, MARK2), inWin(POS_RESET, '0)};
      floor_q <= floorCode({inWin(POS_RESET, POS_TOP), inWin(POS_RESET, MARK2), inWin(POS_RESET, '0)});
    end else begin
      red_q   <= ~hit;
      floor_q <= floorCode(hit);
    end
  end

  assign red1      = red_q[0];
  assign red2      = red_q[1];
  assign red3      = red_q[2];
  assign floor_pos = floor_q;

endmodule

// File: doc/elevator_shaft_model.md
Name: elevator_shaft_model

Overview:
- Synthesizable cabin/shaft emulator. It produces the three active-low floor sensor lines (red1..red3) that the elevator controller consumes.
- It closes the loop from the motor side: the controller's up/down drive commands move a virtual cabin position, and the block answers with sensor levels.
- Used for hardware-in-the-loop demos on the board without the physical shaft, and as the sensor source in system benches instead of hand-timed sensor waveforms.

Parameters:
- TICKS_PER_FLOOR, 1000: position ticks between adjacent floor marks.
- CLK_DIV, 50: sysclk cycles per position tick while moving (>=2).
- WIN, 20: half-width, in ticks, of each sensor's active window (< TICKS_PER_FLOOR/2).
- START_FLOOR, 2: floor (1..3) the cabin sits at after reset.

Ports:
- sysclk  input  1  system clock.
- SW0  input  1  reset; asynchronous, active-low.
- motor_up  input  1  drive cabin upward while high.
- motor_down  input  1  drive cabin downward while high.
- red1  output  1  floor-1 sensor; 0 = cabin aligned.
- red2  output  1  floor-2 sensor; 0 = cabin aligned.
- red3  output  1  floor-3 sensor; 0 = cabin aligned.
- floor_pos  output  2  1..3 = cabin inside that floor's window; 0 = between floors.
- moving  output  1  1 in MOVE_UP/MOVE_DOWN.
- fault  output  1  sticky fault flag.

Behaviour:

Position register:
- pos, unsigned, width $clog2(2*TICKS_PER_FLOOR+1).
- Floor N mark = (N-1)*TICKS_PER_FLOOR. POS_MAX = 2*TICKS_PER_FLOOR.

Reset (SW0=0, asynchronous):
- state=IDLE, pos=(START_FLOOR-1)*TICKS_PER_FLOOR, prescaler=0, fault=0, moving=0.
- red(START_FLOOR)=0, other red lines=1, floor_pos=START_FLOOR.
- Every output has these values while SW0=0 and on the first edge after release.

Prescaler:
- Counts 0..CLK_DIV-1 only in MOVE_UP/MOVE_DOWN. Step strobe fires when prescaler==CLK_DIV-1, then it wraps to 0.
- Forced to 0 in IDLE and FAULT.

FSM (evaluated every sysclk edge):
- IDLE:
  - motor_up&motor_down -> FAULT.
  - motor_up -> MOVE_UP.
  - motor_down -> MOVE_DOWN.
  - else stay.
- MOVE_UP:
  - motor_down=1 -> FAULT (priority over everything).
  - motor_up=0 -> IDLE; pos unchanged, partial prescaler count discarded.
  - On step with pos<POS_MAX -> pos+1.
  - On step with pos==POS_MAX -> FAULT (overtravel); pos stays POS_MAX.
- MOVE_DOWN:
  - Mirror of MOVE_UP. motor_up=1 -> FAULT. Step at pos==0 -> FAULT; pos stays 0.
- FAULT:
  - Absorbing until SW0 asserted. pos and prescaler frozen; fault=1; moving=0.
  - Sensor outputs keep reflecting the frozen pos.
- First movement step occurs CLK_DIV cycles after entering a MOVE state. Reversal therefore needs a pass through IDLE (at least one cycle with both commands low).

Sensor outputs:
- Registered, updated one cycle after pos changes.
- redN=0 iff |pos - markN| <= WIN, else 1. Use width-safe comparisons: no unsigned wrap below 0, pos is never compared beyond POS_MAX.
- Windows never overlap, so at most one red line is low.
- floor_pos is encoded from the same registered comparisons and is consistent with red1..3 in the same cycle.

Outputs moving and fault:
- moving=1 exactly while state is MOVE_UP/MOVE_DOWN (registered with state).
- fault goes high the cycle FAULT is entered.

Test Plan (defaults TPF=1000, CLK_DIV=50, WIN=20, START_FLOOR=2):
1. Reset:
   - Hold SW0=0 and toggle commands -> red1=1, red2=0, red3=1, floor_pos=2, moving=0, fault=0.
   - Deassert SW0 mid-move and reassert -> outputs return to these values asynchronously.
2. Travel up:
   - Release SW0, hold motor_up -> red2 rises after 21 steps (pos=1021, ~1050 cycles).
   - red3 falls at pos=1980 (980 steps, ~49000 cycles +1); floor_pos=3 in the same cycle.
3. Stop mid-shaft:
   - Drop motor_up at pos=1500 -> next cycle moving=0, all red=1, floor_pos=0, pos stays 1500 for 10000 cycles.
   - Re-assert motor_up -> first step exactly 50 cycles later.
4. Overtravel:
   - Keep motor_up until pos=2000 -> on the next step fault=1, moving=0, pos=2000, red3=0.
   - Further commands are ignored until SW0 pulse.
5. Conflicting commands:
   - In IDLE drive motor_up=motor_down=1 for 1 cycle -> fault=1 next edge.
   - During MOVE_DOWN assert motor_up -> fault=1 next edge, pos frozen.
6. Down to floor 1:
   - From reset hold motor_down -> red2 rises at pos=979; red1 falls at pos=20, floor_pos=1.
   - Release there -> IDLE, red1 held 0.
